// File: rtl/alu_decode_stage.sv
// RV32I decode stage (OP, OP-IMM, LUI) feeding the ALU, with a 2-entry skid buffer on the output.
// Optional DECODE_STATS_EN adds saturating transfer counters count_decoded / count_illegal.
module alu_decode_stage #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned PC_EN_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        instr,
   input  logic [PC_EN_W-1:0] pc_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2:0]         fn,
   output logic [6:0]         funct7,
   output logic [4:0]         rs1_addr,
   output logic [4:0]         rs2_addr,
   output logic [4:0]         rd_addr,
   output logic [XLEN-1:0]    imm,
   output logic               use_imm,
   output logic               reg_write,
   output logic               illegal,
   output logic [PC_EN_W-1:0] pc_out
`ifdef DECODE_STATS_EN
   ,
   output logic [31:0]        count_decoded,
   output logic [31:0]        count_illegal
`endif
);

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [6:0] OpcLui   = 7'b0110111;
   localparam logic [6:0] F7Alt    = 7'b0100000;

   typedef struct packed {
      logic [2:0]         fn;
      logic [6:0]         funct7;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [4:0]         rd;
      logic [XLEN-1:0]    imm;
      logic               use_imm;
      logic               reg_write;
      logic               illegal;
      logic [PC_EN_W-1:0] pc;
   } bundle_t;

   bundle_t          w_dec;
   bundle_t          r_main;
   bundle_t          r_skid;
   logic             r_main_valid;
   logic             r_skid_valid;
   logic             w_accept;
   logic             w_drain;
   logic [2:0]       w_f3;
   logic [6:0]       w_f7;
   logic             w_bad;
   logic [XLEN-1:0]  w_imm_i;
   logic [XLEN-1:0]  w_imm_u;

   assign w_f3    = instr[14:12];
   assign w_f7    = instr[31:25];
   assign w_imm_i = XLEN'($signed(instr[31:20]));
   assign w_imm_u = XLEN'($signed({instr[31:12], 12'b0}));

   always_comb begin
      w_dec     = '0;
      w_bad     = 1'b0;
      w_dec.rs1 = instr[19:15];
      w_dec.rs2 = instr[24:20];
      w_dec.rd  = instr[11:7];
      w_dec.pc  = pc_in;
      unique case (instr[6:0])
         OpcOp: begin
            w_dec.fn     = w_f3;
            w_dec.funct7 = w_f7;
            w_bad        = !((w_f7 == 7'b0) || ((w_f7 == F7Alt) &&
                                                ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
         end
         OpcOpImm: begin
            w_dec.fn      = w_f3;
            w_dec.use_imm = 1'b1;
            w_dec.imm     = w_imm_i;
            // Only shifts carry a funct7; everything else forces 0 so ADDI never subtracts.
            if (w_f3 == 3'b001) begin
               w_bad = (w_f7 != 7'b0);
            end else if (w_f3 == 3'b101) begin
               w_dec.funct7 = w_f7;
               w_bad        = !((w_f7 == 7'b0) || (w_f7 == F7Alt));
            end
         end
         OpcLui: begin
            w_dec.rs1     = 5'd0;
            w_dec.rs2     = 5'd0;
            w_dec.use_imm = 1'b1;
            w_dec.imm     = w_imm_u;
         end
         default: w_bad = 1'b1;
      endcase
      if (w_bad) begin
         w_dec.fn      = 3'b000;
         w_dec.funct7  = 7'b0;
         w_dec.imm     = '0;
         w_dec.use_imm = 1'b0;
      end
      w_dec.illegal   = w_bad;
      w_dec.reg_write = !w_bad && (w_dec.rd != 5'd0);
   end

   assign w_accept = in_valid && in_ready;
   assign w_drain  = r_main_valid && out_ready;

   // SKID is only ever full while MAIN is full, so MAIN refills from SKID before taking input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main       <= '0;
         r_skid       <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (r_skid_valid) begin
         if (w_drain) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
         end
      end else if (!r_main_valid || w_drain) begin
         r_main_valid <= w_accept;
         if (w_accept) r_main <= w_dec;
      end else if (w_accept) begin
         r_skid_valid <= 1'b1;
         r_skid       <= w_dec;
      end
   end

   assign in_ready  = !r_skid_valid;
   assign out_valid = r_main_valid;
   assign fn        = r_main.fn;
   assign funct7    = r_main.funct7;
   assign rs1_addr  = r_main.rs1;
   assign rs2_addr  = r_main.rs2;
   assign rd_addr   = r_main.rd;
   assign imm       = r_main.imm;
   assign use_imm   = r_main.use_imm;
   assign reg_write = r_main.reg_write;
   assign illegal   = r_main.illegal;
   assign pc_out    = r_main.pc;

`ifdef DECODE_STATS_EN
   logic [31:0] r_cnt_decoded;
   logic [31:0] r_cnt_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_decoded <= '0;
         r_cnt_illegal <= '0;
      end else if (w_drain) begin
         if (r_cnt_decoded != '1) r_cnt_decoded <= r_cnt_decoded + 32'd1;
         if (r_main.illegal && (r_cnt_illegal != '1)) r_cnt_illegal <= r_cnt_illegal + 32'd1;
      end
   end

   assign count_decoded = r_cnt_decoded;
   assign count_illegal = r_cnt_illegal;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed cases, stall/flush/reset scenarios, random traffic.
// Honours DECODE_STATS_EN for the optional counters.
module tb_alu_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc_in;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  fn;
   logic [6:0]  funct7;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [31:0] imm;
   logic        use_imm, reg_write, illegal;
   logic [31:0] pc_out;
`ifdef DECODE_STATS_EN
   logic [31:0] count_decoded, count_illegal;
   logic [31:0] n_out = 0;
   logic [31:0] n_ill = 0;
`endif

   alu_decode_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc_in     (pc_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fn        (fn),
      .funct7    (funct7),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rd_addr   (rd_addr),
      .imm       (imm),
      .use_imm   (use_imm),
      .reg_write (reg_write),
      .illegal   (illegal),
      .pc_out    (pc_out)
`ifdef DECODE_STATS_EN
      ,
      .count_decoded (count_decoded),
      .count_illegal (count_illegal)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      logic [2:0]  fn;
      logic [6:0]  f7;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic        use_imm, reg_write, illegal;
      logic [31:0] pc;
      bit          chk_regs, chk_rs2, chk_imm;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] pc_ctr   = 32'h1000;
   bit          rnd_done;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference decode written from the ISA rules, classifying each instruction by opcode.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
      exp_t       e;
      logic [2:0] f3;
      logic [6:0] f7;
      bit         is_op, is_opi, is_lui, legal;
      f3     = ins[14:12];
      f7     = ins[31:25];
      is_op  = (ins[6:0] == 7'h33);
      is_opi = (ins[6:0] == 7'h13);
      is_lui = (ins[6:0] == 7'h37);
      legal  = 0;
      if (is_op)       legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      else if (is_opi) legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1;
      else if (is_lui) legal = 1;
      e.ins       = ins;
      e.pc        = pc;
      e.rd        = ins[11:7];
      e.rs1       = is_lui ? 5'd0 : ins[19:15];
      e.rs2       = ins[24:20];
      e.illegal   = !legal;
      e.reg_write = legal && (ins[11:7] != 0);
      e.chk_regs  = legal;
      e.chk_rs2   = legal && is_op;
      e.chk_imm   = !(legal && is_op);
      e.fn        = 0;
      e.f7        = 0;
      e.imm       = 0;
      e.use_imm   = 0;
      if (legal && is_lui) begin
         e.imm     = ins & 32'hFFFF_F000;
         e.use_imm = 1;
      end else if (legal && is_opi) begin
         e.fn      = f3;
         e.f7      = (f3 == 5) ? f7 : 7'h0;
         e.imm     = $signed(ins) >>> 20;
         e.use_imm = 1;
      end else if (legal) begin
         e.fn = f3;
         e.f7 = f7;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 4))
         0, 4:    w[6:0] = 7'h33;
         1:       w[6:0] = 7'h13;
         2:       w[6:0] = 7'h37;
         default: ;
      endcase
      if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
      return w;
   endfunction

   // Monitor: sampled on the falling edge, describing the transfers of the next rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", {32'b0, pc_out}, 64'hDEAD);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk($sformatf("illegal[%h]", e.ins), illegal, e.illegal);
               chk($sformatf("reg_write[%h]", e.ins), reg_write, e.reg_write);
               chk($sformatf("fn[%h]", e.ins), fn, e.fn);
               chk($sformatf("funct7[%h]", e.ins), funct7, e.f7);
               chk($sformatf("rd[%h]", e.ins), rd_addr, e.rd);
               chk($sformatf("pc[%h]", e.ins), pc_out, e.pc);
               if (e.chk_regs) begin
                  chk($sformatf("rs1[%h]", e.ins), rs1_addr, e.rs1);
                  chk($sformatf("use_imm[%h]", e.ins), use_imm, e.use_imm);
               end
               if (e.chk_rs2) chk($sformatf("rs2[%h]", e.ins), rs2_addr, e.rs2);
               if (e.chk_imm) chk($sformatf("imm[%h]", e.ins), imm, e.imm);
`ifdef DECODE_STATS_EN
               if (n_out != 32'hFFFF_FFFF) n_out++;
               if (e.illegal && n_ill != 32'hFFFF_FFFF) n_ill++;
`endif
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back(model(instr, pc_in));
      end
   end

   task automatic send(input logic [31:0] ins);
      int n = 0;
      in_valid = 1;
      instr    = ins;
      pc_in    = pc_ctr;
      pc_ctr   = pc_ctr + 4;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) chk("send_timeout", 1, 0);
      @(posedge clk);
      #1 in_valid = 0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", n >= 200, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string name);
      bit seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk(name, seen, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_stats();
`ifdef DECODE_STATS_EN
      chk("count_decoded", count_decoded, n_out);
      chk("count_illegal", count_illegal, n_ill);
`endif
   endtask

   initial begin
      rst_n     = 0;
      flush     = 0;
      in_valid  = 0;
      instr     = 0;
      pc_in     = 0;
      out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fn", fn, 0);
      chk("rst_imm", imm, 0);
      chk("rst_pc_out", pc_out, 0);
      chk("rst_rd_reg_write", {rd_addr, reg_write, illegal, use_imm}, 0);
      @(negedge clk);
      rst_n = 1;
      #1 chk("rst_in_ready", in_ready, 1);
      check_stats();
      @(posedge clk);
      #1;

      // Directed decodes at full throughput.
      out_ready = 1;
      send(32'h002081B3);
      chk("latency_out_valid", out_valid, 1);
      send(32'h402081B3);
      send(32'h4030D093);
      send(32'hFFF00293);
      send(32'h12345037);
      wait_drain();

      // Four instructions against a 3-cycle stall.
      out_ready = 0;
      send(32'h00310233);
      send(32'h00A00513);
      chk("stall_in_ready_low", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      fork
         begin
            send(32'h4062D393);
            send(32'h000FF437);
         end
         begin
            @(posedge clk);
            #1 out_ready = 1;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               chk($sformatf("no_gap_%0d", i), out_valid, 1);
            end
         end
      join
      wait_drain();
      check_stats();

      // Illegal encodings still flow through.
      send(32'h00000000);
      send(32'h422081B3);
      wait_drain();
      check_stats();

      // Flush with both entries full and a pending input.
      out_ready = 0;
      send(32'h00108093);
      send(32'h00210113);
      in_valid = 1;
      instr    = 32'h00318193;
      flush    = 1;
      @(posedge clk);
      #1 flush = 0;
      in_valid = 0;
      chk("flush_full_out_valid", out_valid, 0);
      chk("flush_full_in_ready", in_ready, 1);
      // Flush coinciding with an accepted input.
      send(32'h00420213);
      in_valid = 1;
      instr    = 32'h00528293;
      flush    = 1;
      @(posedge clk);
      #1 flush = 0;
      in_valid = 0;
      chk("flush_accept_out_valid", out_valid, 0);
      out_ready = 1;
      check_quiet("flush_nothing_emerges");
      check_stats();

      // Random traffic with random backpressure.
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end else begin
                  send(rand_instr());
               end
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1;
      wait_drain();
      chk("sb_empty", sb.size(), 0);
      check_stats();

      // Asynchronous reset while holding two bundles.
      out_ready = 0;
      send(32'h002081B3);
      send(32'h4030D093);
      #2 rst_n = 0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_fn_f7", {fn, funct7}, 0);
      chk("async_rst_imm", imm, 0);
      chk("async_rst_pc", pc_out, 0);
      sb.delete();
`ifdef DECODE_STATS_EN
      n_out = 0;
      n_ill = 0;
`endif
      @(negedge clk);
      rst_n = 1;
      #1 chk("post_rst_in_ready", in_ready, 1);
      check_stats();
      out_ready = 1;
      check_quiet("post_rst_quiet");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
